// File: rtl/image_buffer_reader_pkg.sv
// Shared types and default sizing for the image buffer reader and its output FIFO.
package image_buffer_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    localparam int DEFAULT_READ_LATENCY = 2;
    localparam int DEFAULT_FIFO_DEPTH   = 4;

endpackage

// File: rtl/image_buffer_reader_fifo.sv
// Show-ahead byte FIFO: o_data is the head entry whenever o_valid is high; zero when empty.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clock_in,
    input  logic                       reset_in,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_valid,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop_ok;

    assign w_pop_ok = i_pop && (r_count != '0);

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, w_pop_ok};
        end
    end

    // Storage needs no reset: the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clock_in) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_valid = (r_count != '0);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

    a_no_overflow: assert property (@(posedge clock_in) disable iff (reset_in)
        !(i_push && !i_flush && !w_pop_ok && (r_count == (AW+1)'(DEPTH))))
        else $error("byte_fifo: push into full FIFO");

endmodule

// File: rtl/image_buffer_reader.sv
// Streams a block of bytes out of a fixed-latency image buffer read port into a
// valid/ready byte stream, keeping at most FIFO_DEPTH bytes buffered or in flight.
module image_buffer_reader
    import image_buffer_reader_pkg::*;
#(
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic        start_in,
    input  logic [15:0] start_address_in,
    input  logic [16:0] byte_count_in,
    input  logic        abort_in,
    output logic [15:0] read_address_out,
    input  logic [7:0]  read_data_in,
    output logic [7:0]  data_out,
    output logic        data_valid_out,
    input  logic        data_ready_in,
    output logic        busy_out,
    output logic        done_out,
    output state_t      debug_state_out
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [15:0]             r_addr_next;
    logic [15:0]             r_rd_addr;
    logic [16:0]             r_remaining;
    logic [READ_LATENCY-1:0] r_valid_sr;
    logic                    r_done;
    logic                    w_start;
    logic                    w_issue;
    logic                    w_done_next;
    logic                    w_pop;
    logic                    w_fifo_valid;
    logic [CW-1:0]           w_fifo_count;
    logic [7:0]              w_inflight;
    logic [7:0]              w_occupancy;

    // Stream handshake: a byte moves when data_valid_out and data_ready_in are both
    // high at a rising edge; data_out holds while valid is high and ready is low.
    assign w_start = (r_state == ST_IDLE) && start_in && !abort_in;
    assign w_pop   = w_fifo_valid && data_ready_in;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_inflight = w_inflight + 8'(r_valid_sr[i]);
        end
        w_occupancy = w_inflight + 8'(w_fifo_count);
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A pop in the same cycle is not credited, so a FIFO slot is always free on return.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    if (byte_count_in == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_state_next = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (w_occupancy < 8'(FIFO_DEPTH)) begin
                    w_issue = 1'b1;
                    if (r_remaining == 17'd1) begin
                        w_state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if ((w_inflight == '0) &&
                    ((w_fifo_count == '0) || ((w_fifo_count == CW'(1)) && w_pop))) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (abort_in) begin
            w_state_next = ST_IDLE;
            w_issue      = 1'b0;
            w_done_next  = 1'b0;
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_addr_next <= '0;
            r_rd_addr   <= '0;
            r_remaining <= '0;
            r_valid_sr  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_done_next;
            if (abort_in) begin
                r_valid_sr <= '0;
            end else begin
                r_valid_sr <= (r_valid_sr << 1) | READ_LATENCY'(w_issue);
            end
            if (w_start) begin
                r_addr_next <= start_address_in;
                r_remaining <= byte_count_in;
            end else if (w_issue) begin
                r_rd_addr   <= r_addr_next;
                r_addr_next <= r_addr_next + 16'd1;
                r_remaining <= r_remaining - 17'd1;
            end
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .i_flush  (abort_in),
        .i_push   (r_valid_sr[READ_LATENCY-1]),
        .i_data   (read_data_in),
        .i_pop    (w_pop),
        .o_data   (data_out),
        .o_valid  (w_fifo_valid),
        .o_count  (w_fifo_count)
    );

    assign read_address_out = r_rd_addr;
    assign data_valid_out   = w_fifo_valid;
    assign busy_out         = (r_state != ST_IDLE);
    assign done_out         = r_done;
    assign debug_state_out  = r_state;

endmodule

// File: tb/tb_image_buffer_reader.sv
// Bench for image_buffer_reader: RAM model returns addr[7:0], expected bytes are queued
// at start and popped by an independent monitor on every accepted transfer.
module tb_image_buffer_reader;
  import image_buffer_reader_pkg::*;

  localparam int L     = DEFAULT_READ_LATENCY;
  localparam int DEPTH = DEFAULT_FIFO_DEPTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        start_in = 1'b0;
  logic [15:0] start_address_in = '0;
  logic [16:0] byte_count_in = '0;
  logic        abort_in = 1'b0;
  logic [15:0] read_address_out;
  logic [7:0]  read_data_in;
  logic [7:0]  data_out;
  logic        data_valid_out;
  logic        data_ready_in = 1'b0;
  logic        busy_out;
  logic        done_out;
  state_t      debug_state;

  image_buffer_reader dut (
    .clock_in         (clk),
    .reset_in         (rst),
    .start_in         (start_in),
    .start_address_in (start_address_in),
    .byte_count_in    (byte_count_in),
    .abort_in         (abort_in),
    .read_address_out (read_address_out),
    .read_data_in     (read_data_in),
    .data_out         (data_out),
    .data_valid_out   (data_valid_out),
    .data_ready_in    (data_ready_in),
    .busy_out         (busy_out),
    .done_out         (done_out),
    .debug_state_out  (debug_state)
  );

  // Image buffer: address launched at edge k is captured by the reader at edge k+L.
  logic [7:0] ram_pipe [L-1];
  always @(posedge clk) begin
    ram_pipe[0] <= read_address_out[7:0];
    for (int i = 1; i < L - 1; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign read_data_in = ram_pipe[L-2];

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  int n_acc = 0;
  int n_done = 0;
  int last_acc_cyc = 0;
  int first_valid_cyc = -1;
  int done_cyc = 0;
  int start_cyc = 0;
  int ready_mode = 0;  // 0 high, 1 random 50%, 2 low, 3 mostly high
  bit hold_pending = 1'b0;
  logic [7:0] held_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- consumer ready driver ----------------
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: data_ready_in = 1'b1;
      1: data_ready_in = 1'($urandom_range(0, 1));
      2: data_ready_in = 1'b0;
      default: data_ready_in = ($urandom_range(0, 15) != 0);
    endcase
  end

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (hold_pending && data_valid_out) check("hold_stable", data_out, held_data);
      if (data_valid_out) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (data_ready_in) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got %0h expected none (cycle %0d)", data_out, cyc);
          end else begin
            check("data", data_out, exp_q.pop_front());
          end
          n_acc++;
          last_acc_cyc = cyc;
        end
      end
      if (done_out) begin
        n_done++;
        done_cyc = cyc;
      end
    end
    hold_pending = !rst && data_valid_out && !data_ready_in;
    held_data = data_out;
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [15:0] addr, input logic [16:0] cnt, input bit accepted);
    @(posedge clk);
    #1;
    start_in = 1'b1;
    start_address_in = addr;
    byte_count_in = cnt;
    if (accepted) begin
      for (int i = 0; i < int'(cnt); i++) exp_q.push_back(8'(addr + 16'(i)));
    end
    @(posedge clk);
    #1;
    start_in = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy_out || exp_q.size() != 0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_in_time"}, 32'(n < budget), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int d0;
    int base;
    int issued;
    logic [15:0] a5;
    logic [15:0] a9;
    logic [15:0] addr;
    logic [16:0] cnt;

    // reset values
    #2;
    check("rst_addr", read_address_out, 16'h0);
    check("rst_data", data_out, 8'h0);
    check("rst_valid", data_valid_out, 1'b0);
    check("rst_busy", busy_out, 1'b0);
    check("rst_done", done_out, 1'b0);
    check("rst_state", debug_state, ST_IDLE);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // basic stream, latency and throughput
    ready_mode = 0;
    repeat (2) @(posedge clk);
    d0 = n_done;
    first_valid_cyc = -1;
    do_start(16'h0010, 17'd8, 1'b1);
    check("t1_busy", busy_out, 1'b1);
    wait_idle("t1", 100);
    check("t1_first_latency", first_valid_cyc - start_cyc, 3);
    check("t1_consecutive", last_acc_cyc - first_valid_cyc, 7);
    check("t1_done_count", n_done - d0, 1);
    check("t1_done_timing", done_cyc, last_acc_cyc + 1);

    // backpressure stall mid-stream, plus start while busy (ignored)
    d0 = n_done;
    base = n_acc;
    do_start(16'h0200, 17'd16, 1'b1);
    for (int k = 0; k < 60 && n_acc < base + 3; k++) begin
      @(posedge clk);
      #1;
    end
    ready_mode = 2;
    a5 = '0;
    a9 = '0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) begin
        start_in = 1'b1;
        start_address_in = 16'h5555;
        byte_count_in = 17'd3;
      end
      if (k == 3) start_in = 1'b0;
      if (k == 5) a5 = read_address_out;
      if (k == 9) a9 = read_address_out;
    end
    issued = int'(read_address_out) - 'h200 + 1;
    check("t2_addr_stalled", a9, a5);
    check("t2_outstanding", issued - (n_acc - base), DEPTH);
    check("t2_valid_held", data_valid_out, 1'b1);
    ready_mode = 0;
    wait_idle("t2", 200);
    check("t2_done_count", n_done - d0, 1);

    // address wrap
    d0 = n_done;
    do_start(16'hFFFE, 17'd4, 1'b1);
    wait_idle("t3", 100);
    check("t3_last_addr", read_address_out, 16'h0001);
    check("t3_done_count", n_done - d0, 1);

    // zero-length request
    d0 = n_done;
    do_start(16'h1234, 17'd0, 1'b1);
    check("t4_done_pulse", done_out, 1'b1);
    check("t4_busy", busy_out, 1'b0);
    @(posedge clk);
    #1;
    check("t4_done_drop", done_out, 1'b0);
    check("t4_busy2", busy_out, 1'b0);
    check("t4_done_count", n_done - d0, 1);

    // abort after 3 bytes, with a simultaneous start that must lose
    d0 = n_done;
    base = n_acc;
    do_start(16'h0300, 17'd20, 1'b1);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #2;
      if (n_acc >= base + 3) break;
    end
    data_ready_in = 1'b0;
    ready_mode = 2;
    abort_in = 1'b1;
    start_in = 1'b1;
    start_address_in = 16'h0040;
    byte_count_in = 17'd5;
    @(posedge clk);
    #1;
    abort_in = 1'b0;
    start_in = 1'b0;
    exp_q.delete();
    check("t5_valid_low", data_valid_out, 1'b0);
    check("t5_busy_low", busy_out, 1'b0);
    check("t5_accepted", n_acc - base, 3);
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_done", n_done - d0, 0);
    check("t5_still_idle", busy_out, 1'b0);
    ready_mode = 0;
    do_start(16'h0000, 17'd2, 1'b1);
    wait_idle("t5b", 100);
    check("t5b_done_count", n_done - d0, 1);

    // asynchronous reset mid-transfer
    ready_mode = 1;
    d0 = n_done;
    do_start(16'h0500, 17'd50, 1'b1);
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t6_addr", read_address_out, 16'h0);
    check("t6_data", data_out, 8'h0);
    check("t6_valid", data_valid_out, 1'b0);
    check("t6_busy", busy_out, 1'b0);
    check("t6_done", done_out, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t6_no_done", n_done - d0, 0);
    check("t6_idle", busy_out, 1'b0);

    // random short transfers under random backpressure
    for (int t = 0; t < 6; t++) begin
      ready_mode = 1;
      addr = 16'($urandom);
      cnt = 17'($urandom_range(1, 40));
      d0 = n_done;
      do_start(addr, cnt, 1'b1);
      wait_idle("t7", 500);
      check("t7_done_count", n_done - d0, 1);
    end

    // full 64 KiB transfer with random backpressure
    ready_mode = 3;
    d0 = n_done;
    addr = 16'($urandom);
    do_start(addr, 17'h10000, 1'b1);
    wait_idle("t8", 120000);
    check("t8_done_count", n_done - d0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/image_buffer_reader.md
IMAGE_BUFFER_READER -- requirements
Module: image_buffer_reader

Interface
REQ-001 Parameter READ_LATENCY, default 2, cycles from read_address_out presented to matching read_data_in valid.
REQ-002 Parameter FIFO_DEPTH, default 4, output byte FIFO entries; SHALL be ≥ READ_LATENCY+2 and a power of two.
REQ-003 clock_in  input  1  single clock, same clock as image buffer read side.
REQ-004 reset_in  input  1  asynchronous, active-high reset.
REQ-005 start_in  input  1  one-cycle request to begin streaming.
REQ-006 start_address_in  input  16  first byte address, sampled with start_in.
REQ-007 byte_count_in  input  17  bytes to stream (0..65536), sampled with start_in.
REQ-008 abort_in  input  1  cancel current transfer.
REQ-009 read_address_out  output  16  byte address to image buffer read port.
REQ-010 read_data_in  input  8  byte from image buffer, READ_LATENCY cycles after address.
REQ-011 data_out  output  8  streamed byte (FIFO head).
REQ-012 data_valid_out  output  1  data_out valid.
REQ-013 data_ready_in  input  1  consumer accepts; transfer when valid and ready high at rising edge.
REQ-014 busy_out  output  1  transfer in progress.
REQ-015 done_out  output  1  one-cycle pulse on normal completion.

Function
REQ-016 States IDLE, STREAM, DRAIN; busy_out SHALL be high in STREAM and DRAIN only.
REQ-017 IDLE + start_in + byte_count_in≠0 -> STREAM; address counter loads start_address_in, remaining-issue counter loads byte_count_in.
REQ-018 IDLE + start_in + byte_count_in=0 -> stay IDLE, done_out pulses next cycle.
REQ-019 start_in while busy SHALL be ignored.
REQ-020 In STREAM a read issues in a cycle iff fifo_count + inflight_count < FIFO_DEPTH (same-cycle pop not credited); issued address held on read_address_out (registered), counter then increments.
REQ-021 Address SHALL wrap 16'hFFFF -> 16'h0000.
REQ-022 Issue tracked by READ_LATENCY-bit valid shift register; read_data_in pushed into FIFO in the cycle the tail bit is set.
REQ-023 STREAM -> DRAIN after last read issued; DRAIN -> IDLE with done_out pulse when inflight=0, FIFO empty and final byte accepted.
REQ-024 FIFO is show-ahead: data_valid_out = FIFO non-empty; data_out SHALL hold stable while valid and not ready.
REQ-025 Sustained throughput one byte per cycle with data_ready_in high.
REQ-026 Bytes delivered in exact address order, none duplicated or dropped under any backpressure pattern.
REQ-027 abort_in (any state) -> IDLE next cycle, FIFO and in-flight flushed, data_valid_out low, no done_out; abort_in and start_in together: abort wins.
REQ-028 FIFO never overflows; push into full FIFO is a design error asserted in simulation.
REQ-029 Caller guarantees no image buffer writes during transfer; block does not detect them.

Reset
REQ-030 On reset_in: state IDLE, read_address_out=0, data_out=0, data_valid_out=0, busy_out=0, done_out=0, counters, shift register and FIFO cleared.
REQ-031 Reset asserted mid-transfer SHALL take effect immediately; no done_out on release.

Structure
REQ-032 Package image_buffer_reader_pkg holds state enum and default READ_LATENCY/FIFO_DEPTH constants.
REQ-033 One sub-module byte_fifo (synchronous, show-ahead, count output, same reset).

Verification
REQ-034 RAM model byte=addr[7:0]; start addr 0x0010, count 8, ready high -> data 0x10..0x17 consecutive cycles, first valid 3 cycles after start edge, done_out once after 0x17.
REQ-035 Count 16, ready low 10 cycles mid-stream -> ≤FIFO_DEPTH outstanding, read_address_out stalls, all 16 bytes in order.
REQ-036 Start 0xFFFE, count 4 -> addresses FFFE, FFFF, 0000, 0001; data FE, FF, 00, 01.
REQ-037 Count 0 -> busy_out never high, done_out pulse one cycle after start.
REQ-038 Abort after 3 bytes of 20 -> next cycle valid and busy low, no done; new start addr 0 count 2 -> 00, 01, done.
REQ-039 reset_in asserted mid-transfer -> all outputs zero asynchronously; random ready pattern, count 65536 -> scoreboard match.
